// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks microsteps of the current instruction through a
// synchronous microcode ROM (1-cycle read latency). Each microstep spends one
// enabled cycle presenting the ROM address (ADDR) and one enabled cycle
// asserting the returned control word (EXEC). A word with bit 15 set halts the
// sequencer until reset. A zero word or the last step (F) retires the
// instruction.
//
// Optional build macro: SEQ_SINGLE_STEP_EN adds the step_req input; ADDR then
// only advances on cycles where both en and step_req are high.
module microcode_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step_req,
`endif
  input  logic [7:0]  instruction,
  input  logic [15:0] rom_data,
  output logic [7:0]  rom_addr,
  output logic [15:0] ctrl,
  output logic [3:0]  step,
  output logic        halted,
  output logic        instr_done,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ADDR = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] step_n;
  logic       done_n;
  logic       advance_ok;

  // ADDR->EXEC qualifier: plain enable, or enable plus a single-step request.
`ifdef SEQ_SINGLE_STEP_EN
  assign advance_ok = en & step_req;
`else
  assign advance_ok = en;
`endif

  // The instruction is only ever observed here, so a change during EXEC
  // naturally takes effect at the next ADDR.
  assign rom_addr  = {instruction[7:4], step};
  assign halted    = (state == HALT);
  assign fsm_state = state;

  // State, step and the registered retirement pulse; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ADDR;
      step       <= 4'h0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      instr_done <= done_n;
    end
  end

  // Next-state, next-step, retirement and control-line gating.
  always_comb begin
    state_n = state;
    step_n  = step;
    done_n  = 1'b0;
    ctrl    = 16'h0000;
    case (state)
      ADDR: begin
        if (advance_ok) state_n = EXEC;
      end
      EXEC: begin
        if (en) begin
          // Reset in the same cycle suppresses the control word entirely.
          if (!rst) ctrl = rom_data;
          if (rom_data[15]) begin
            state_n = HALT;
          end else if ((rom_data == 16'h0000) || (step == 4'hF)) begin
            step_n  = 4'h0;
            done_n  = 1'b1;
            state_n = ADDR;
          end else begin
            step_n  = step + 4'd1;
            state_n = ADDR;
          end
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = ADDR;
      end
    endcase
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: clk input, 1 bit, rising-edge system clock; rst input, 1 bit, synchronous active-high reset.
REQ-002 The block SHALL have port en: input, 1 bit, clock enable for microstep advance.
REQ-003 The block SHALL have port instruction: input, 8 bits, instruction register contents; only [7:4] are used.
REQ-004 The block SHALL have port rom_data: input, 16 bits, control word from the microcode ROM, registered with 1-cycle read latency.
REQ-005 The block SHALL have port rom_addr: output, 8 bits, microcode ROM read address.
REQ-006 The block SHALL have port ctrl: output, 16 bits, gated control lines to the datapath.
REQ-007 The block SHALL have port step: output, 4 bits, current microstep.
REQ-008 The block SHALL have port halted: output, 1 bit, high while in HALT.
REQ-009 The block SHALL have port instr_done: output, 1 bit, one-cycle pulse when an instruction retires.

Function
REQ-010 rom_addr SHALL be combinational {instruction[7:4], step}.
REQ-011 The FSM SHALL have exactly three states: ADDR (address presented, ROM read in flight), EXEC (rom_data valid, control asserted) and HALT.
REQ-012 In ADDR with en=1, the FSM SHALL go to EXEC; in ADDR with en=0, it SHALL stay in ADDR.
REQ-013 ctrl SHALL equal rom_data only when state=EXEC and en=1; otherwise ctrl SHALL be 16'h0000, so each control word is asserted for exactly one enabled edge.
REQ-014 In EXEC with en=0, the FSM SHALL hold state and step, with ctrl=0.
REQ-015 In EXEC with en=1 and rom_data[15]=1 (HLT), the FSM SHALL go to HALT; step SHALL be unchanged and instr_done SHALL stay 0.
REQ-016 In EXEC with en=1, rom_data[15]=0, and either rom_data==16'h0000 or step==4'hF, step SHALL become 0, instr_done SHALL pulse high on the next cycle for one cycle, and the FSM SHALL go to ADDR.
REQ-017 Otherwise, in EXEC with en=1, step SHALL become step+1 and the FSM SHALL go to ADDR.
REQ-018 Step SHALL never exceed 4'hF; wrap-around from F to 0 SHALL count as retirement per REQ-016.
REQ-019 In HALT, ctrl SHALL be 0 and halted SHALL be 1; HALT SHALL be left only by rst, and en SHALL be ignored.
REQ-020 Each microstep SHALL take exactly 2 enabled cycles (ADDR + EXEC).
REQ-021 instruction SHALL be sampled only through rom_addr; a change to instruction during EXEC SHALL take effect at the next ADDR.

Reset
REQ-022 rst SHALL have priority over en and all state; in any state it SHALL force state=ADDR and step=0.
REQ-023 On the cycle after rst, outputs SHALL be ctrl=0, halted=0, instr_done=0 and rom_addr={instruction[7:4],4'h0}.
REQ-024 rst asserted mid-EXEC SHALL suppress any ctrl assertion in that cycle and SHALL suppress any instr_done pulse.

Configuration
REQ-025 When SEQ_SINGLE_STEP_EN is defined, the block SHALL add input step_req (1 bit), and ADDR->EXEC SHALL require en=1 and step_req=1, giving one microstep per step_req-qualified cycle.
REQ-026 When SEQ_SINGLE_STEP_EN is undefined, the step_req port SHALL be absent and ADDR->EXEC SHALL follow REQ-012.

Verification
REQ-027 Fetch scenario: instruction=8'h00, en=1, ROM model 00->4004, 01->1408, 02->0000 -> ctrl=4004 in cycle 2, ctrl=1408 in cycle 4, ctrl=0 in cycle 6, instr_done pulse in cycle 7, step back to 0.
REQ-028 Halt scenario: instruction=8'hF0, ROM F2->8000 -> halted=1 after step 2, and ctrl stays 0 for 20 further en cycles.
REQ-029 Wrap scenario: instruction=8'h30, all sixteen ROM words 0001 -> step goes 0..F, then 0, with instr_done after step F.
REQ-030 Enable stall scenario: en=0 for 5 cycles mid-EXEC -> ctrl=0, step held, and execution resumes with an identical ctrl sequence.
REQ-031 Reset scenario: rst pulsed during step 2 EXEC, and separately during HALT -> step=0, halted=0, ctrl=0, and no instr_done pulse.
REQ-032 Single-step scenario (SEQ_SINGLE_STEP_EN defined): step_req pulsed 3 times -> exactly 3 nonzero ctrl assertions.
